// File: rtl/lut_pkg.sv
// rtl/lut_pkg.sv - shared defaults and state encoding for the branch-target table
package lut_pkg;

  localparam int              DEPTH_W_DEF  = 5;
  localparam int              DATA_W_DEF   = 10;
  localparam logic [9:0]      INIT_VAL_DEF = 10'h001;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_SEARCH = 2'd2
  } state_t;

endpackage

// File: rtl/target_lut_if.sv
// rtl/target_lut_if.sv - write, read and reverse-lookup signals of the target table
interface target_lut_if #(
  parameter int DEPTH_W = 5,
  parameter int DATA_W  = 10
);
  logic               clear;
  logic               wr_valid;
  logic               wr_ready;
  logic [DEPTH_W-1:0] wr_addr;
  logic [DATA_W-1:0]  wr_data;
  logic [DEPTH_W-1:0] rd_addr;
  logic [DATA_W-1:0]  rd_target;
  logic               srch_valid;
  logic               srch_ready;
  logic [DATA_W-1:0]  srch_data;
  logic               srch_done;
  logic               srch_hit;
  logic [DEPTH_W-1:0] srch_idx;
  logic               busy;

  modport master (
    output clear, wr_valid, wr_addr, wr_data, rd_addr, srch_valid, srch_data,
    input  wr_ready, rd_target, srch_ready, srch_done, srch_hit, srch_idx, busy
  );

  modport slave (
    input  clear, wr_valid, wr_addr, wr_data, rd_addr, srch_valid, srch_data,
    output wr_ready, rd_target, srch_ready, srch_done, srch_hit, srch_idx, busy
  );
endinterface

// File: rtl/target_lut_mem.sv
// rtl/target_lut_mem.sv - register array, one synchronous write port, two combinational reads
module target_lut_mem #(
  parameter int DEPTH_W = 5,
  parameter int DATA_W  = 10
) (
  input  logic               clk,
  input  logic               we,
  input  logic [DEPTH_W-1:0] waddr,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [DEPTH_W-1:0] raddr_a,
  output logic [DATA_W-1:0]  rdata_a,
  input  logic [DEPTH_W-1:0] raddr_b,
  output logic [DATA_W-1:0]  rdata_b
);

  // Storage is deliberately unreset; the controller's INIT pass defines it.
  logic [DATA_W-1:0] mem [2**DEPTH_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/target_lut_ctrl.sv
// rtl/target_lut_ctrl.sv - table init, handshaked target writes and sequential reverse lookup
module target_lut_ctrl
  import lut_pkg::*;
#(
  parameter int               DEPTH_W  = DEPTH_W_DEF,
  parameter int               DATA_W   = DATA_W_DEF,
  parameter logic [DATA_W-1:0] INIT_VAL = INIT_VAL_DEF
) (
  input logic         clk,
  input logic         rst,
  target_lut_if.slave bus
);

  localparam logic [DEPTH_W-1:0] LAST = '1;

  state_t             state, state_n;
  logic [DEPTH_W-1:0] cnt, cnt_n;
  logic [DEPTH_W-1:0] idx, idx_n;
  logic [DATA_W-1:0]  key, key_n;
  logic               done, done_n;
  logic               hit, hit_n;
  logic [DEPTH_W-1:0] sidx, sidx_n;

  logic               we;
  logic [DEPTH_W-1:0] waddr;
  logic [DATA_W-1:0]  wdata;
  logic [DATA_W-1:0]  srch_q;
  logic               wr_ready, srch_ready;

  target_lut_mem #(.DEPTH_W(DEPTH_W), .DATA_W(DATA_W)) u_mem (
    .clk     (clk),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (bus.rd_addr),
    .rdata_a (bus.rd_target),
    .raddr_b (idx),
    .rdata_b (srch_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_INIT;
      cnt   <= '0;
      idx   <= '0;
      key   <= '0;
      done  <= 1'b0;
      hit   <= 1'b0;
      sidx  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      key   <= key_n;
      done  <= done_n;
      hit   <= hit_n;
      sidx  <= sidx_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    idx_n      = idx;
    key_n      = key;
    done_n     = 1'b0;
    hit_n      = hit;
    sidx_n     = sidx;
    we         = 1'b0;
    waddr      = bus.wr_addr;
    wdata      = bus.wr_data;
    wr_ready   = 1'b0;
    srch_ready = 1'b0;
    case (state)
      ST_INIT: begin
        if (bus.clear) begin
          cnt_n = '0;
        end else begin
          we    = 1'b1;
          waddr = cnt;
          wdata = INIT_VAL;
          if (cnt == LAST) begin
            cnt_n   = '0;
            state_n = ST_IDLE;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      ST_IDLE: begin
        if (bus.clear) begin
          cnt_n   = '0;
          state_n = ST_INIT;
        end else begin
          // A pending write always wins over a search in the same cycle.
          wr_ready   = 1'b1;
          srch_ready = !bus.wr_valid;
          if (bus.wr_valid) begin
            we = 1'b1;
          end else if (bus.srch_valid) begin
            key_n   = bus.srch_data;
            idx_n   = '0;
            state_n = ST_SEARCH;
          end
        end
      end
      ST_SEARCH: begin
        if (bus.clear) begin
          cnt_n   = '0;
          state_n = ST_INIT;
        end else if (srch_q == key) begin
          done_n  = 1'b1;
          hit_n   = 1'b1;
          sidx_n  = idx;
          state_n = ST_IDLE;
        end else if (idx == LAST) begin
          done_n  = 1'b1;
          hit_n   = 1'b0;
          sidx_n  = '0;
          state_n = ST_IDLE;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = ST_INIT;
      end
    endcase
  end

  assign bus.wr_ready   = wr_ready;
  assign bus.srch_ready = srch_ready;
  assign bus.srch_done  = done;
  assign bus.srch_hit   = hit;
  assign bus.srch_idx   = sidx;
  assign bus.busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_target_lut_ctrl.sv
// tb/tb_target_lut_ctrl.sv - directed self-checking bench for target_lut_ctrl
module tb_target_lut_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  target_lut_if #(.DEPTH_W(5), .DATA_W(10)) bus ();

  target_lut_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.srch_done && n < 100) begin
      tick();
      n++;
    end
  endtask

  int n;
  int saw_done;

  initial begin
    bus.clear      = 1'b0;
    bus.wr_valid   = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.rd_addr    = '0;
    bus.srch_valid = 1'b0;
    bus.srch_data  = '0;

    tick();
    tick();
    check("rst_busy", bus.busy, 1);
    check("rst_wr_ready", bus.wr_ready, 0);
    check("rst_srch_ready", bus.srch_ready, 0);
    check("rst_done", bus.srch_done, 0);
    check("rst_hit", bus.srch_hit, 0);
    check("rst_idx", bus.srch_idx, 0);

    rst = 1'b0;
    wait_idle(n);
    check("init_cycles", n, 32);
    check("idle_wr_ready", bus.wr_ready, 1);
    check("idle_srch_ready", bus.srch_ready, 1);
    for (int a = 0; a < 32; a++) begin
      bus.rd_addr = 5'(a);
      #1;
      check($sformatf("init_rd%0d", a), bus.rd_target, 10'h001);
    end

    // Write and search raised together: write wins, search waits.
    bus.wr_valid   = 1'b1;
    bus.wr_addr    = 5'd3;
    bus.wr_data    = 10'h3FF;
    bus.srch_valid = 1'b1;
    bus.srch_data  = 10'h3FF;
    bus.rd_addr    = 5'd3;
    #1;
    check("wr_ready_accept", bus.wr_ready, 1);
    check("srch_ready_blocked", bus.srch_ready, 0);
    check("rd3_before_edge", bus.rd_target, 10'h001);
    tick();
    bus.wr_valid = 1'b0;
    #1;
    check("rd3_after_write", bus.rd_target, 10'h3FF);
    check("srch_ready_after_wr", bus.srch_ready, 1);
    check("no_search_yet", bus.busy, 0);
    bus.rd_addr = 5'd2;
    #1;
    check("rd2_untouched", bus.rd_target, 10'h001);

    tick();
    bus.srch_valid = 1'b0;
    check("search_busy", bus.busy, 1);
    wait_done(n);
    check("hit_latency", n, 4);
    check("hit_flag", bus.srch_hit, 1);
    check("hit_idx", bus.srch_idx, 3);
    tick();
    check("done_pulse", bus.srch_done, 0);
    check("idle_after_hit", bus.busy, 0);

    bus.srch_valid = 1'b1;
    bus.srch_data  = 10'h155;
    tick();
    bus.srch_valid = 1'b0;
    wait_done(n);
    check("miss_latency", n, 32);
    check("miss_flag", bus.srch_hit, 0);
    check("miss_idx", bus.srch_idx, 0);
    tick();

    // Re-establish a hit so an aborted search can be seen not to disturb it.
    bus.srch_valid = 1'b1;
    bus.srch_data  = 10'h3FF;
    tick();
    bus.srch_valid = 1'b0;
    wait_done(n);
    check("hit2_latency", n, 4);
    tick();

    bus.srch_valid = 1'b1;
    bus.srch_data  = 10'h155;
    tick();
    bus.srch_valid = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.srch_done) saw_done++;
    end
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin
      if (bus.srch_done) saw_done++;
      tick();
      n++;
    end
    check("abort_no_done", saw_done, 0);
    check("abort_init_cycles", n, 32);
    check("abort_hit_hold", bus.srch_hit, 1);
    check("abort_idx_hold", bus.srch_idx, 3);
    bus.rd_addr = 5'd3;
    #1;
    check("rd3_after_clear", bus.rd_target, 10'h001);

    // Clear beats a simultaneous write in IDLE.
    bus.clear    = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 5'd5;
    bus.wr_data  = 10'h0AA;
    #1;
    check("clear_blocks_wr", bus.wr_ready, 0);
    check("clear_blocks_srch", bus.srch_ready, 0);
    tick();
    bus.clear    = 1'b0;
    bus.wr_valid = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    check("mid_init_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    check("async_rst_hit", bus.srch_hit, 0);
    check("async_rst_idx", bus.srch_idx, 0);
    check("async_rst_busy", bus.busy, 1);
    check("async_rst_wr_ready", bus.wr_ready, 0);
    tick();
    rst = 1'b0;
    wait_idle(n);
    check("reinit_cycles", n, 32);
    bus.rd_addr = 5'd5;
    #1;
    check("rd5_after_reinit", bus.rd_target, 10'h001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
